// File: rtl/fp_mult_issue_stage.sv
// fp_mult_issue_stage
//   Valid/ready front-end and registered result stage wrapped around an
//   external combinational FloatingPointMultiplier. Operand pairs are queued
//   in a small FIFO. The head pair is driven to the multiplier, and its
//   product is fixed up for special cases and then registered with
//   exception flags.
//
//   Optional feature: define FP_MULT_STICKY_FLAGS_EN to add accumulated
//   (sticky) exception flags with a clear input.
//
//   out_flags = {invalid, overflow, underflow, zero}
module fp_mult_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  output logic [31:0]                mul_a,
  output logic [31:0]                mul_b,
  input  logic [31:0]                mul_product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_product,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef FP_MULT_STICKY_FLAGS_EN
  ,
  output logic [3:0]                 sticky_flags,
  input  logic                       flags_clr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      mem_a [DEPTH];
  logic [31:0]      mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic load;

  // Decoded operand fields of the head pair
  logic [7:0]  a_exp;
  logic [7:0]  b_exp;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        sign;
  logic [8:0]  e_sum;
  logic [31:0] fix_product;
  logic [3:0]  fix_flags;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign load     = !empty && (!out_valid || out_ready);

  assign fifo_count = count;
  assign mul_a      = empty ? 32'h0 : mem_a[rd_ptr];
  assign mul_b      = empty ? 32'h0 : mem_b[rd_ptr];

  assign a_exp  = mul_a[30:23];
  assign b_exp  = mul_b[30:23];
  assign a_nan  = (&a_exp) && (|mul_a[22:0]);
  assign b_nan  = (&b_exp) && (|mul_b[22:0]);
  assign a_inf  = (&a_exp) && !(|mul_a[22:0]);
  assign b_inf  = (&b_exp) && !(|mul_b[22:0]);
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign sign   = mul_a[31] ^ mul_b[31];
  assign e_sum  = {1'b0, a_exp} + {1'b0, b_exp};

  // Special-case fix-up of the raw product, highest priority first
  always_comb begin
    fix_product = mul_product;
    fix_flags   = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      fix_product = 32'h7FC0_0000;
      fix_flags   = 4'b1000;
    end else if (a_inf || b_inf) begin
      fix_product = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      fix_product = {sign, 31'h0};
      fix_flags   = 4'b0001;
    end else if ((e_sum >= 9'd382) || ((e_sum == 9'd381) && (&mul_product[30:23]))) begin
      fix_product = {sign, 8'hFF, 23'h0};
      fix_flags   = 4'b0100;
    end else if (e_sum <= 9'd126) begin
      fix_product = {sign, 31'h0};
      fix_flags   = 4'b0011;
    end
  end

  // Operand storage, written on push; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !load) begin
        count <= count + 1'b1;
      end else if (!push && load) begin
        count <= count - 1'b1;
      end
    end
  end

  // Result register: capture on load, hold until the consumer accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= 32'h0;
      out_flags   <= 4'b0000;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_product <= fix_product;
      out_flags   <= fix_flags;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef FP_MULT_STICKY_FLAGS_EN
  // Sticky flags accumulate every load; a load in the same cycle as a clear keeps its own flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= 4'b0000;
    end else if (load) begin
      sticky_flags <= (flags_clr ? 4'b0000 : sticky_flags) | fix_flags;
    end else if (flags_clr) begin
      sticky_flags <= 4'b0000;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mult_issue_stage.sv
// tb_fp_mult_issue_stage
//   Directed-vector bench for fp_mult_issue_stage. A simple truncating
//   behavioural multiplier stands in for FloatingPointMultiplier. Expected
//   results are hand-computed and queued. They are compared in order as
//   results are accepted on the output side.
module tb_fp_mult_issue_stage;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [31:0]   mul_product;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_product;
  logic [3:0]    out_flags;
  logic [CW-1:0] fifo_count;
`ifdef FP_MULT_STICKY_FLAGS_EN
  logic [3:0]    sticky_flags;
  logic          flags_clr;
`endif

  logic [35:0] expQ [$];
  logic [35:0] monExp;
  int          vectorsApplied = 0;
  int          miscompares    = 0;

  fp_mult_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_flags   (out_flags),
    .fifo_count  (fifo_count)
`ifdef FP_MULT_STICKY_FLAGS_EN
    ,
    .sticky_flags(sticky_flags),
    .flags_clr   (flags_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating multiplier model for normal operands; special cases are overridden by the DUT
  function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma;
    logic [47:0] mb;
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    ma = {24'h0, 1'b1, a[22:0]};
    mb = {24'h0, 1'b1, b[22:0]};
    p  = ma * mb;
    if (p[47]) begin
      m = p[46:24];
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd126;
    end else begin
      m = p[45:23];
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  always_comb mul_product = modelMul(mul_a, mul_b);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Offer one operand pair until accepted, queueing its expected result
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expProd, input logic [3:0] expFlags);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int t = 0; t < 40 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        expQ.push_back({expFlags, expProd});
      end
      stepCycle();
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", {31'h0, in_ready}, 32'd1);
  endtask

  task automatic waitDrain(input string tag);
    int t;
    t = 0;
    while ((expQ.size() != 0 || out_valid) && t < 60) begin
      stepCycle();
      t++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  // Output-side scoreboard: every accepted result must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("stale_result", {31'h0, out_valid}, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("product", out_product, monExp[31:0]);
        checkOutput("flags", {28'h0, out_flags}, {28'h0, monExp[35:32]});
      end
    end
  end

  logic [31:0] bVals [6];

  initial begin
    bVals[0] = 32'h3F80_0000;
    bVals[1] = 32'h4000_0000;
    bVals[2] = 32'h4040_0000;
    bVals[3] = 32'h4080_0000;
    bVals[4] = 32'h40A0_0000;
    bVals[5] = 32'h40C0_0000;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
`ifdef FP_MULT_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("rst_out_product", out_product, 32'h0);
    checkOutput("rst_out_flags", {28'h0, out_flags}, 32'h0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("rst_mul_a", mul_a, 32'h0);

    // Latency: push at edge k, out_valid after edge k+1
    in_valid = 1'b1;
    in_a     = 32'h4000_0000;
    in_b     = 32'h4040_0000;
    expQ.push_back({4'b0000, 32'h40C0_0000});
    stepCycle();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_edge_k", {31'h0, out_valid}, 32'd0);
    checkOutput("lat_count", 32'(fifo_count), 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("lat_edge_k1", {31'h0, out_valid}, 32'd1);
    stepCycle();
    waitDrain("drain_t1");

    // Special cases and exponent boundaries
    applyStimulus(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
    applyStimulus(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
    applyStimulus(32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000, 4'b1000);
    applyStimulus(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000);
    applyStimulus(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0100);
    applyStimulus(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011);
    applyStimulus(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0001);
    applyStimulus(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0001);
    applyStimulus(32'h7F40_0000, 32'h3FC0_0000, 32'h7F80_0000, 4'b0100);
    applyStimulus(32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 4'b0000);
    applyStimulus(32'h0080_0000, 32'h3E80_0000, 32'h0000_0000, 4'b0011);
    applyStimulus(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0000);
    applyStimulus(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'b0000);
    applyStimulus(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000);
    applyStimulus(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000);
    waitDrain("drain_special");

    // Back-pressure: five pushes fill output register plus FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h3F80_0000, bVals[i], bVals[i], 4'b0000);
    end
    in_valid = 1'b1;
    in_a     = 32'h3F80_0000;
    in_b     = bVals[5];
    @(negedge clk);
    checkOutput("full_in_ready", {31'h0, in_ready}, 32'd0);
    checkOutput("full_count", 32'(fifo_count), 32'd4);
    checkOutput("stall_valid", {31'h0, out_valid}, 32'd1);
    checkOutput("stall_product", out_product, bVals[0]);
    stepCycle();
    checkOutput("stall_hold", out_product, bVals[0]);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_ready_with_load", {31'h0, in_ready}, 32'd0);
    stepCycle();
    begin
      bit accepted;
      accepted = 1'b0;
      for (int t = 0; t < 20 && !accepted; t++) begin
        @(negedge clk);
        if (in_ready) begin
          accepted = 1'b1;
          expQ.push_back({4'b0000, bVals[5]});
        end
        stepCycle();
      end
      in_valid = 1'b0;
      checkOutput("sixth_accepted", {31'h0, accepted}, 32'd1);
    end
    waitDrain("drain_bp");

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h3F80_0000, bVals[i+1], bVals[i+1], 4'b0000);
    end
    @(negedge clk);
    checkOutput("pre_rst_count", 32'(fifo_count), 32'd3);
    checkOutput("pre_rst_valid", {31'h0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("async_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("async_rst_product", out_product, 32'h0);
    expQ.delete();
    stepCycle();
    stepCycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) stepCycle();
    checkOutput("post_rst_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("post_rst_count", 32'(fifo_count), 32'd0);
    applyStimulus(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000);
    waitDrain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
